// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch front end: FSM states and the
// {pc, instr} entry carried through the fetch buffer.
package fetch_pkg;

    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular fetch buffer with flush. A push into a full buffer is accepted
// when a pop happens on the same edge.
module fetch_fifo #(
    parameter int  DEPTH   = 2,
    parameter type entry_t = logic [63:0]
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push_i,
    input  entry_t data_i,
    input  logic   pop_i,
    input  logic   flush_i,
    output entry_t head_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q, count_d;
    logic            do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    // Empty head reads as zero so the decode side never sees stale data.
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop)
            count_d = count_q + 1'b1;
        else if (do_pop && !do_push)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i)
            mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, reads the zero-latency ROM and queues
// {pc, instr} pairs for decode; traps reads of unmapped ROM words.
module instr_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          FIFO_DEPTH    = 2,
    parameter logic [31:0] UNMAPPED_WORD = 32'hAAAA_AAAA
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_instr_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        fault_o,
    output logic [31:0] fault_pc_o,
    input  logic        fault_clr_i
);

    fetch_state_e  state_q;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic          fault_q;
    logic [31:0]   fault_pc_q;

    fetch_entry_t  head, push_entry;
    logic          fifo_full, fifo_empty;
    logic          pop, space, attempt, unmapped, push;

    assign rom_addr_o = fetch_pc_q;
    assign fetch_pc_d = fetch_pc_q + 32'(INSTR_BYTES);

    assign valid_o    = !fifo_empty;
    assign instr_o    = head.instr;
    assign pc_o       = head.pc;
    assign fault_o    = fault_q;
    assign fault_pc_o = fault_pc_q;

    assign pop      = valid_o && ready_i;
    assign space    = !fifo_full || pop;
    // Redirect and fault clear both pre-empt the fetch action on this edge.
    assign attempt  = (state_q == FETCH) && en_i && !redirect_i && !fault_clr_i && space;
    assign unmapped = (rom_instr_i == UNMAPPED_WORD);
    assign push     = attempt && !unmapped;

    assign push_entry = '{pc: fetch_pc_q, instr: rom_instr_i};

    fetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (fetch_entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .flush_i (redirect_i),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else if (redirect_i) begin
            fetch_pc_q <= {redirect_pc_i[31:2], 2'b00};
            if (fault_clr_i) begin
                fault_q <= 1'b0;
                state_q <= IDLE;
            end
        end else if (fault_clr_i) begin
            fault_q <= 1'b0;
            state_q <= IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (en_i)
                        state_q <= FETCH;
                end
                FETCH: begin
                    if (!en_i) begin
                        state_q <= IDLE;
                    end else if (attempt) begin
                        if (unmapped) begin
                            fault_q    <= 1'b1;
                            fault_pc_q <= fetch_pc_q;
                            state_q    <= FAULT;
                        end else begin
                            fetch_pc_q <= fetch_pc_d;
                        end
                    end
                end
                FAULT: ;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: directed scenarios plus a random
// run, checked against a queue-based reference model of the fetch rules.
module tb_instr_fetch_ctrl;

    localparam logic [31:0] UNM   = 32'hAAAA_AAAA;
    localparam int          DEPTH = 2;
    localparam logic [31:0] IMG [17] = '{
        32'h0150_0093, 32'h0FF0_0093, 32'h0020_8133, 32'h4011_0133,
        32'h0011_2023, 32'h0000_0000, 32'h0001_2183, 32'h0031_0463,
        32'hFE00_08E3, 32'h0010_0073, 32'h0000_0013, 32'h0041_0113,
        32'h0081_2223, 32'h00C0_006F, 32'h0040_0093, 32'h0000_8067,
        32'h0051_0193
    };

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, en, redir, ready, clr;
    logic [31:0] rpc, rom_addr, rom_instr, instr, pc, fault_pc;
    logic        valid, fault;

    logic        rst2_n, en2, ready2, valid2, fault2;
    logic [31:0] rom_addr2, instr2, pc2, fpc2;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a < 32'h44) return IMG[int'(a >> 2)];
        return UNM;
    endfunction

    assign rom_instr = rom_word(rom_addr);

    instr_fetch_ctrl #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH), .UNMAPPED_WORD(UNM)) dut (
        .clk(clk), .rst_n(rst_n), .en_i(en), .redirect_i(redir), .redirect_pc_i(rpc),
        .rom_addr_o(rom_addr), .rom_instr_i(rom_instr), .instr_o(instr), .pc_o(pc),
        .valid_o(valid), .ready_i(ready), .fault_o(fault), .fault_pc_o(fault_pc),
        .fault_clr_i(clr)
    );

    instr_fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(DEPTH), .UNMAPPED_WORD(UNM)) dut2 (
        .clk(clk), .rst_n(rst2_n), .en_i(en2), .redirect_i(1'b0), .redirect_pc_i(32'h0),
        .rom_addr_o(rom_addr2), .rom_instr_i(32'h0000_0013), .instr_o(instr2), .pc_o(pc2),
        .valid_o(valid2), .ready_i(ready2), .fault_o(fault2), .fault_pc_o(fpc2),
        .fault_clr_i(1'b0)
    );

    // Reference model: state 0=idle 1=fetching 2=faulted, buffer as a queue.
    logic [31:0] m_pc, m_fpc;
    int          m_st;
    bit          m_fault;
    logic [63:0] m_q[$];

    task automatic model_reset(input logic [31:0] rp);
        m_pc = rp; m_st = 0; m_fault = 0; m_fpc = 0; m_q.delete();
    endtask

    task automatic model_step();
        bit          popm, pushm, trap;
        logic [31:0] w;
        popm = (m_q.size() > 0) && ready;
        pushm = 0; trap = 0; w = 0;
        if (redir) begin
            m_q.delete();
            m_pc = {rpc[31:2], 2'b00};
            if (clr) begin m_st = 0; m_fault = 0; end
        end else if (clr) begin
            if (popm) void'(m_q.pop_front());
            m_st = 0; m_fault = 0;
        end else begin
            if (m_st == 1 && en && (m_q.size() < DEPTH || popm)) begin
                w = rom_word(m_pc);
                if (w == UNM) trap = 1; else pushm = 1;
            end
            if (popm) void'(m_q.pop_front());
            if (pushm) begin m_q.push_back({m_pc, w}); m_pc = m_pc + 4; end
            if (trap) begin m_fault = 1; m_fpc = m_pc; end
            if (m_st == 0 && en) m_st = 1;
            else if (m_st == 1 && !en) m_st = 0;
            else if (trap) m_st = 2;
        end
    endtask

    function automatic logic [129:0] exp_outs();
        logic [63:0] h;
        h = (m_q.size() > 0) ? m_q[0] : 64'h0;
        return {m_q.size() > 0, m_fault, m_pc, h, m_fpc};
    endfunction

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0; en = 0; redir = 0; clr = 0; ready = 0; rpc = 0;
        model_reset(32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({valid, fault, rom_addr, pc, instr, fault_pc} !== {1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL reset_state: got v=%b f=%b addr=%h pc=%h instr=%h fpc=%h, exp all zero",
                     valid, fault, rom_addr, pc, instr, fault_pc);
        end
    endtask

    task automatic test_stream();
        logic [63:0] beats[$];
        int bad = 0;
        do_reset();
        en = 1; ready = 1;
        for (int i = 0; i < 40; i++) begin
            step();
            checks++;
            if ({valid, fault, rom_addr, pc, instr, fault_pc} !== exp_outs()) begin
                errors++;
                $display("FAIL stream_cycle%0d: got %h exp %h", i,
                         {valid, fault, rom_addr, pc, instr, fault_pc}, exp_outs());
            end
            if (i == 0) begin
                checks++;
                if (valid !== 1'b0) begin errors++; $display("FAIL stream_latency_early: valid=%b exp 0", valid); end
            end
            if (i == 1) begin
                checks++;
                if ({valid, pc, instr} !== {1'b1, 32'h0, 32'h0150_0093}) begin
                    errors++;
                    $display("FAIL stream_first_beat: v=%b pc=%h instr=%h exp 1/0/01500093", valid, pc, instr);
                end
            end
            if (valid && ready) beats.push_back({pc, instr});
            if (fault && !valid) break;
        end
        checks++;
        if (beats.size() != 17) begin
            errors++; $display("FAIL stream_beat_count: got %0d exp 17", beats.size());
        end
        foreach (beats[k]) if (k < 17 && beats[k] !== {32'(k * 4), IMG[k]}) bad++;
        foreach (beats[k]) if (beats[k][63:32] == 32'h44) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL stream_beat_order: %0d bad beats, exp 0", bad); end
        checks++;
        if ({fault, fault_pc} !== {1'b1, 32'h44}) begin
            errors++; $display("FAIL stream_fault: f=%b fpc=%h exp 1/00000044", fault, fault_pc);
        end
    endtask

    task automatic test_clear_redirect();
        redir = 1; rpc = 32'h0; clr = 1; en = 0;
        step();
        redir = 0; clr = 0;
        checks++;
        if ({fault, rom_addr, valid} !== {1'b0, 32'h0, 1'b0}) begin
            errors++; $display("FAIL clr_redirect: f=%b addr=%h v=%b exp 0/0/0", fault, rom_addr, valid);
        end
        en = 1; ready = 1;
        step();
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL clr_idle_latency: valid=%b exp 0", valid); end
        step();
        checks++;
        if ({valid, pc, instr} !== {1'b1, 32'h0, 32'h0150_0093}) begin
            errors++; $display("FAIL clr_first_beat: v=%b pc=%h instr=%h exp 1/0/01500093", valid, pc, instr);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] got[$];
        do_reset();
        en = 1; ready = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if ({valid, fault, rom_addr, pc, instr, fault_pc} !== exp_outs()) begin
                errors++;
                $display("FAIL bp_cycle%0d: got %h exp %h", i, {valid, fault, rom_addr, pc, instr, fault_pc}, exp_outs());
            end
            if (i >= 1) begin
                checks++;
                if ({valid, pc, instr} !== {1'b1, 32'h0, 32'h0150_0093}) begin
                    errors++; $display("FAIL bp_hold%0d: v=%b pc=%h instr=%h", i, valid, pc, instr);
                end
            end
        end
        checks++;
        if (rom_addr !== 32'h8) begin errors++; $display("FAIL bp_stall_pc: addr=%h exp 00000008", rom_addr); end
        ready = 1;
        for (int i = 0; i < 3; i++) begin
            if (valid) got.push_back(pc);
            step();
        end
        checks++;
        if (got.size() != 3 || got[0] !== 32'h0 || got[1] !== 32'h4 || got[2] !== 32'h8) begin
            errors++; $display("FAIL bp_release: got %0d beats, exp pcs 0,4,8", got.size());
        end
    endtask

    task automatic test_redirect();
        do_reset();
        en = 1; ready = 0;
        repeat (4) step();
        ready = 1; redir = 1; rpc = 32'h0E;
        step();
        redir = 0;
        checks++;
        if ({valid, rom_addr} !== {1'b0, 32'hC}) begin
            errors++; $display("FAIL redirect_flush: v=%b addr=%h exp 0/0000000c", valid, rom_addr);
        end
        step();
        checks++;
        if ({valid, pc, instr} !== {1'b1, 32'hC, IMG[3]}) begin
            errors++; $display("FAIL redirect_beat: v=%b pc=%h instr=%h exp 1/c/%h", valid, pc, instr, IMG[3]);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        ready = 0; redir = 1; rpc = 32'h40;
        step();
        redir = 0; en = 1;
        repeat (3) step();
        checks++;
        if ({valid, fault, rom_addr, pc, instr, fault_pc} !== exp_outs() || !(valid && fault)) begin
            errors++; $display("FAIL pre_reset_fault: got %h exp %h", {valid, fault, rom_addr, pc, instr, fault_pc}, exp_outs());
        end
        #2 rst_n = 0;
        #1;
        checks++;
        if ({valid, fault, rom_addr, fault_pc} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
            errors++; $display("FAIL async_reset: v=%b f=%b addr=%h fpc=%h exp all 0", valid, fault, rom_addr, fault_pc);
        end
        do_reset();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            en    = ($urandom % 8) != 0;
            ready = ($urandom % 3) != 0;
            redir = ($urandom % 16) == 0;
            rpc   = $urandom_range(0, 32'h50);
            clr   = ($urandom % 12) == 0;
            step();
            checks++;
            if ({valid, fault, rom_addr, pc, instr, fault_pc} !== exp_outs()) begin
                errors++;
                $display("FAIL random_cycle%0d: got %h exp %h", i, {valid, fault, rom_addr, pc, instr, fault_pc}, exp_outs());
            end
        end
        en = 0; ready = 0; redir = 0; clr = 0;
    endtask

    task automatic test_wrap();
        logic [63:0] beats[$];
        en = 0; redir = 0; clr = 0;
        rst2_n = 0; en2 = 0; ready2 = 1;
        step();
        rst2_n = 1; en2 = 1;
        for (int i = 0; i < 8 && beats.size() < 2; i++) begin
            step();
            if (valid2 && ready2) beats.push_back({pc2, instr2});
        end
        checks++;
        if (beats.size() != 2 || beats[0] !== {32'hFFFF_FFFC, 32'h13} || beats[1] !== {32'h0, 32'h13}) begin
            errors++; $display("FAIL wrap_beats: got %0d beats, exp fffffffc then 0 with instr 13", beats.size());
        end
        #2 rst2_n = 0;
        #1;
        checks++;
        if ({valid2, fault2, rom_addr2} !== {1'b0, 1'b0, 32'hFFFF_FFFC}) begin
            errors++; $display("FAIL wrap_async_reset: v=%b f=%b addr=%h exp 0/0/fffffffc", valid2, fault2, rom_addr2);
        end
    endtask

    initial begin
        rst2_n = 0; en2 = 0; ready2 = 0;
        test_reset();
        test_stream();
        test_clear_redirect();
        test_backpressure();
        test_redirect();
        test_async_reset();
        test_random();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
